// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive front end.
// Holds the frame FSM state encoding and the 3-sample majority voter.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter (0..P-1, wraps at P-1) and data-bit counter.
// Clear has priority over enable/increment on both counters.
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cnt_en,
  input  logic               cnt_clr,
  input  logic [PRESC_W-1:0] presc,
  input  logic               bit_inc,
  input  logic               bit_clr,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               edge_last
);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;

  // Any Prescale value still wraps here, so the FSM always leaves every bit.
  assign edge_last = (edge_cnt_q == presc - PRESC_W'(1));
  assign edge_cnt  = edge_cnt_q;
  assign bit_cnt   = bit_cnt_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (cnt_clr) begin
      edge_cnt_d = '0;
    end else if (cnt_en) begin
      edge_cnt_d = edge_last ? '0 : edge_cnt_q + PRESC_W'(1);
    end
    if (bit_clr) begin
      bit_cnt_d = '0;
    end else if (bit_inc) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX framing: start detect, 3-sample majority vote per bit, deserializer
// strobes, and parity/stop checking with a data_valid strobe at end of frame.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               RX_clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic               sampled_bit,
  output logic               deser_en,
  output logic               done,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic               smp_lo_q, smp_lo_d;
  logic               smp_mid_q, smp_mid_d;
  logic               sampled_bit_q, sampled_bit_d;
  logic               par_acc_q, par_acc_d;
  logic               par_err_q, par_err_d;
  logic               stp_err_q, stp_err_d;

  logic               cnt_en, cnt_clr, bit_inc, bit_clr, edge_last;
  logic [PRESC_W-1:0] edge_cnt, half;
  logic [BIT_W-1:0]   bit_cnt;
  logic               at_hm1, at_h, at_hp1, at_hp2, last_bit;

  uart_rx_edge_bit_cnt #(
    .PRESC_W(PRESC_W),
    .BIT_W  (BIT_W)
  ) u_cnt (
    .clk      (RX_clk),
    .rst      (rst),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .presc    (presc_q),
    .bit_inc  (bit_inc),
    .bit_clr  (bit_clr),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .edge_last(edge_last)
  );

  // Vote window sits on the bit centre; the voted bit is usable one edge later.
  assign half     = presc_q >> 1;
  assign at_hm1   = (edge_cnt == half - PRESC_W'(1));
  assign at_h     = (edge_cnt == half);
  assign at_hp1   = (edge_cnt == half + PRESC_W'(1));
  assign at_hp2   = (edge_cnt == half + PRESC_W'(2));
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  assign sampled_bit = sampled_bit_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    smp_lo_d      = smp_lo_q;
    smp_mid_d     = smp_mid_q;
    sampled_bit_d = sampled_bit_q;
    par_acc_d     = par_acc_q;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    cnt_en        = 1'b0;
    cnt_clr       = 1'b0;
    bit_inc       = 1'b0;
    bit_clr       = 1'b0;
    deser_en      = 1'b0;
    done          = 1'b0;
    data_valid    = 1'b0;

    if (state_q != IDLE) begin
      cnt_en = 1'b1;
      if (at_hm1) smp_lo_d = RX_IN;
      if (at_h)   smp_mid_d = RX_IN;
      if (at_hp1) sampled_bit_d = maj3(smp_lo_q, smp_mid_q, RX_IN);
    end

    case (state_q)
      IDLE: begin
        // The detect cycle itself is edge 0 of the start bit.
        if (!RX_IN) begin
          state_d   = START;
          cnt_en    = 1'b1;
          bit_clr   = 1'b1;
          presc_d   = Prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_acc_d = 1'b0;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end
      end
      START: begin
        if (edge_last) begin
          if (!sampled_bit_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end
        end
      end
      DATA: begin
        if (at_hp2) begin
          deser_en  = 1'b1;
          par_acc_d = par_acc_q ^ sampled_bit_q;
        end
        if (edge_last) begin
          if (last_bit) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      PARITY: begin
        if (at_hp2) par_err_d = (sampled_bit_q != (par_acc_q ^ par_typ_q));
        if (edge_last) state_d = STOP;
      end
      STOP: begin
        // Leaving mid-bit lets a start bit right after the stop bit be caught.
        if (at_hp2) begin
          stp_err_d  = ~sampled_bit_q;
          done       = 1'b1;
          data_valid = ~par_err_q & sampled_bit_q;
          state_d    = IDLE;
          cnt_clr    = 1'b1;
        end else if (edge_last) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge RX_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      smp_lo_q      <= 1'b0;
      smp_mid_q     <= 1'b0;
      sampled_bit_q <= 1'b0;
      par_acc_q     <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      smp_lo_q      <= smp_lo_d;
      smp_mid_q     <= smp_mid_d;
      sampled_bit_q <= sampled_bit_d;
      par_acc_q     <= par_acc_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: per-cycle comparison against a
// waveform-level frame model, plus a frame table and hand-written corner cases.
module tb_uart_rx_frame_ctrl;

  localparam int DW   = 8;
  localparam int PW   = 6;
  localparam int MAXN = 4096;

  logic          RX_clk;
  logic          rst;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          sampled_bit, deser_en, done, data_valid, par_err, stp_err;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .RX_clk     (RX_clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .sampled_bit(sampled_bit),
    .deser_en   (deser_en),
    .done       (done),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial RX_clk = 1'b0;
  always #5 RX_clk = ~RX_clk;

  // Stimulus waveform, one entry per clock cycle.
  bit            rx_w   [MAXN];
  logic [PW-1:0] pre_w  [MAXN];
  bit            pen_w  [MAXN];
  bit            ptyp_w [MAXN];
  int            n_w;

  // Expected per-cycle outputs.
  bit ex_de[MAXN], ex_bit[MAXN], ex_done[MAXN], ex_dv[MAXN], ex_pe[MAXN], ex_se[MAXN];

  // Observations gathered during a run.
  int         o_de, o_done, o_first, o_dvcnt;
  bit         o_dv, o_pe, o_se;
  logic [7:0] o_byte;

  int n_vec, n_err, cur_cyc;

  typedef struct {
    logic [PW-1:0] p;
    bit            pe;
    bit            pt;
    logic [7:0]    data;
    bit            flip;
    bit            stop;
    int            exp_de;
    int            exp_dones;
    bit            exp_dv;
    bit            exp_perr;
    bit            exp_serr;
    logic [7:0]    exp_byte;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cur_cyc, act, exp);
    end
  endtask

  function automatic bit rbit();
    return bit'($urandom & 1);
  endfunction

  function automatic logic [PW-1:0] rand_p();
    case ($urandom_range(2))
      0:       return PW'(8);
      1:       return PW'(16);
      default: return PW'(32);
    endcase
  endfunction

  task automatic wave_clear();
    n_w = 0;
  endtask

  task automatic push(input bit v, input logic [PW-1:0] p, input bit pe, input bit pt);
    if (n_w < MAXN) begin
      rx_w[n_w]   = v;
      pre_w[n_w]  = p;
      pen_w[n_w]  = pe;
      ptyp_w[n_w] = pt;
      n_w++;
    end
  endtask

  task automatic wave_idle(input int len, input logic [PW-1:0] p, input bit pe, input bit pt);
    for (int i = 0; i < len; i++) push(1'b1, p, pe, pt);
  endtask

  // Start bit, data LSB first, optional parity, stop; jit scrambles config after the first cycle.
  task automatic wave_frame(input logic [7:0] d, input logic [PW-1:0] p, input bit pe,
                            input bit pt, input bit flip, input bit stop, input bit jit);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt ^ flip);
    bits.push_back(stop);
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < int'(p); k++) begin
        if (jit && !(b == 0 && k == 0)) push(bits[b], rand_p(), rbit(), rbit());
        else                            push(bits[b], p, pe, pt);
      end
    end
  endtask

  function automatic bit rxs(input int i);
    return (i < n_w) ? rx_w[i] : 1'b1;
  endfunction

  function automatic bit vote(input int base, input int h);
    bit a, b, c;
    a = rxs(base + h - 1);
    b = rxs(base + h);
    c = rxs(base + h + 1);
    return (a && b) || (a && c) || (b && c);
  endfunction

  task automatic fill_pe(input int from, input bit v);
    for (int i = from; i < n_w; i++) ex_pe[i] = v;
  endtask

  task automatic fill_se(input int from, input bit v);
    for (int i = from; i < n_w; i++) ex_se[i] = v;
  endtask

  // Frame-level reference: scan for a low sample, then read each bit by voting
  // around its centre and place the resulting strobes at their cycle offsets.
  task automatic run_model();
    int c, t, p, h, d, k, at;
    bit acc, b, pb, sb, perr_new;
    for (int i = 0; i < n_w; i++) begin
      ex_de[i] = 0; ex_bit[i] = 0; ex_done[i] = 0; ex_dv[i] = 0; ex_pe[i] = 0; ex_se[i] = 0;
    end
    c = 0;
    while (c < n_w) begin
      if (rx_w[c]) begin
        c++;
      end else begin
        t = c;
        p = int'(pre_w[t]);
        h = p / 2;
        fill_pe(t + 1, 1'b0);
        fill_se(t + 1, 1'b0);
        if (vote(t, h)) begin
          c = t + p;
        end else begin
          acc = 1'b0;
          for (int i = 0; i < DW; i++) begin
            b  = vote(t + p * (1 + i), h);
            at = t + p * (1 + i) + h + 2;
            if (at < n_w) begin
              ex_de[at]  = 1'b1;
              ex_bit[at] = b;
            end
            acc = acc ^ b;
          end
          k = 1 + DW;
          perr_new = 1'b0;
          if (pen_w[t]) begin
            pb = vote(t + p * k, h);
            perr_new = (pb != (acc ^ ptyp_w[t]));
            fill_pe(t + p * k + h + 3, perr_new);
            k++;
          end
          sb = vote(t + p * k, h);
          d  = t + p * k + h + 2;
          if (d < n_w) begin
            ex_done[d] = 1'b1;
            ex_dv[d]   = !perr_new && sb;
          end
          fill_se(d + 1, !sb);
          c = d + 1;
        end
      end
    end
  endtask

  task automatic run_wave(input bit do_rst);
    bit cap;
    if (do_rst) begin
      rst   = 1'b1;
      RX_IN = 1'b1;
      repeat (2) @(negedge RX_clk);
      rst = 1'b0;
    end
    o_de = 0; o_done = 0; o_first = -1; o_dvcnt = 0;
    o_dv = 0; o_pe = 0; o_se = 0; o_byte = '0; cap = 0;
    for (int c = 0; c < n_w; c++) begin
      @(negedge RX_clk);
      cur_cyc = c;
      check("outs", {27'd0, deser_en, done, data_valid, par_err, stp_err},
            {27'd0, ex_de[c], ex_done[c], ex_dv[c], ex_pe[c], ex_se[c]});
      if (ex_de[c]) check("sampled_bit", {31'd0, sampled_bit}, {31'd0, ex_bit[c]});
      if (cap) begin
        o_pe = par_err;
        o_se = stp_err;
        cap  = 0;
      end
      if (deser_en === 1'b1) begin
        o_de++;
        o_byte = {sampled_bit, o_byte[7:1]};
      end
      if (done === 1'b1) begin
        o_done++;
        if (o_done == 1) o_first = c;
        o_dv    = data_valid;
        o_dvcnt = o_dvcnt + int'(data_valid);
        cap     = 1;
      end
      RX_IN    = rx_w[c];
      Prescale = pre_w[c];
      PAR_EN   = pen_w[c];
      PAR_TYP  = ptyp_w[c];
    end
    cur_cyc = -1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cur_cyc = -1;
    rst = 1'b1; RX_IN = 1'b1; Prescale = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;

    //         p       pe pt data   flip stop de dones dv perr serr byte
    vecs[0] = '{PW'(8),  0, 0, 8'hA5, 0, 1, 8, 1, 1, 0, 0, 8'hA5};
    vecs[1] = '{PW'(16), 1, 0, 8'h3C, 0, 1, 8, 1, 1, 0, 0, 8'h3C};
    vecs[2] = '{PW'(16), 1, 0, 8'h3C, 1, 1, 8, 1, 0, 1, 0, 8'h3C};
    vecs[3] = '{PW'(8),  0, 0, 8'h55, 0, 0, 8, 1, 0, 0, 1, 8'h55};
    vecs[4] = '{PW'(32), 1, 1, 8'h96, 0, 1, 8, 1, 1, 0, 0, 8'h96};
    vecs[5] = '{PW'(8),  1, 1, 8'h00, 1, 1, 8, 1, 0, 1, 0, 8'h00};
    vecs[6] = '{PW'(32), 0, 0, 8'hFF, 0, 0, 8, 1, 0, 0, 1, 8'hFF};

    for (int v = 0; v < 7; v++) begin
      wave_clear();
      wave_idle(5, vecs[v].p, vecs[v].pe, vecs[v].pt);
      wave_frame(vecs[v].data, vecs[v].p, vecs[v].pe, vecs[v].pt, vecs[v].flip, vecs[v].stop, 1'b0);
      wave_idle(2 * int'(vecs[v].p) + 10, vecs[v].p, vecs[v].pe, vecs[v].pt);
      run_model();
      run_wave(1'b1);
      check("tbl_de_cnt",  o_de,     vecs[v].exp_de);
      check("tbl_dones",   o_done,   vecs[v].exp_dones);
      check("tbl_byte",    {24'd0, o_byte}, {24'd0, vecs[v].exp_byte});
      check("tbl_dv",      {31'd0, o_dv}, {31'd0, vecs[v].exp_dv});
      check("tbl_par_err", {31'd0, o_pe}, {31'd0, vecs[v].exp_perr});
      check("tbl_stp_err", {31'd0, o_se}, {31'd0, vecs[v].exp_serr});
      check("tbl_latency", o_first - 5,
            int'(vecs[v].p) * (1 + DW + int'(vecs[v].pe)) + int'(vecs[v].p) / 2 + 2);
    end

    // Short low glitch on an idle line: no strobes at all.
    wave_clear();
    wave_idle(10, PW'(8), 0, 0);
    push(1'b0, PW'(8), 0, 0);
    push(1'b0, PW'(8), 0, 0);
    wave_idle(40, PW'(8), 0, 0);
    run_model();
    run_wave(1'b1);
    check("glitch_de", o_de, 0);
    check("glitch_done", o_done, 0);

    // One flipped sample at the centre of data bit 2 is outvoted.
    wave_clear();
    wave_idle(5, PW'(8), 0, 0);
    wave_frame(8'hA5, PW'(8), 0, 0, 0, 1, 0);
    wave_idle(30, PW'(8), 0, 0);
    rx_w[5 + 8 * 3 + 4] = 1'b0;
    run_model();
    run_wave(1'b1);
    check("flip_byte", {24'd0, o_byte}, 32'h0000_00A5);
    check("flip_dv", {31'd0, o_dv}, 32'd1);

    // Back-to-back frames with no idle gap at P=32.
    wave_clear();
    wave_idle(5, PW'(32), 0, 0);
    wave_frame(8'h01, PW'(32), 0, 0, 0, 1, 0);
    wave_frame(8'hFE, PW'(32), 0, 0, 0, 1, 0);
    wave_idle(80, PW'(32), 0, 0);
    run_model();
    run_wave(1'b1);
    check("b2b_dones", o_done, 2);
    check("b2b_dv_cnt", o_dvcnt, 2);
    check("b2b_de_cnt", o_de, 16);
    check("b2b_byte", {24'd0, o_byte}, 32'h0000_00FE);

    // Config changes after start detect must not affect the frame in flight.
    wave_clear();
    wave_idle(5, PW'(8), 0, 0);
    wave_frame(8'h5A, PW'(8), 0, 0, 0, 1, 0);
    wave_idle(30, PW'(8), 0, 0);
    for (int i = 6; i < n_w; i++) begin
      pre_w[i] = PW'(16);
      pen_w[i] = 1'b1;
    end
    run_model();
    run_wave(1'b1);
    check("latch_byte", {24'd0, o_byte}, 32'h0000_005A);
    check("latch_dv", {31'd0, o_dv}, 32'd1);
    check("latch_latency", o_first - 5, 78);

    // Stop error, then a clean frame clears it.
    wave_clear();
    wave_idle(5, PW'(8), 0, 0);
    wave_frame(8'h55, PW'(8), 0, 0, 0, 0, 0);
    wave_idle(20, PW'(8), 0, 0);
    wave_frame(8'h12, PW'(8), 0, 0, 0, 1, 0);
    wave_idle(30, PW'(8), 0, 0);
    run_model();
    run_wave(1'b1);
    check("serr_clr_dones", o_done, 2);
    check("serr_clr_dv_cnt", o_dvcnt, 1);
    check("serr_clr_stp", {31'd0, o_se}, 32'd0);
    check("serr_clr_byte", {24'd0, o_byte}, 32'h0000_0012);

    // Reset during data bit 4 clears all outputs at once; next frame is clean.
    wave_clear();
    wave_idle(5, PW'(16), 0, 0);
    wave_frame(8'h3C, PW'(16), 0, 0, 0, 1, 0);
    rst = 1'b1;
    RX_IN = 1'b1;
    repeat (2) @(negedge RX_clk);
    rst = 1'b0;
    for (int c = 0; c < 97; c++) begin
      @(negedge RX_clk);
      RX_IN = rx_w[c]; Prescale = pre_w[c]; PAR_EN = pen_w[c]; PAR_TYP = ptyp_w[c];
    end
    @(negedge RX_clk);
    check("pre_rst_sbit", {31'd0, sampled_bit}, 32'd1);
    #1 rst = 1'b1;
    #1 check("rst_outs", {26'd0, sampled_bit, deser_en, done, data_valid, par_err, stp_err}, 32'd0);
    RX_IN = 1'b1;
    @(negedge RX_clk);
    rst = 1'b0;
    wave_clear();
    wave_idle(5, PW'(8), 0, 0);
    wave_frame(8'h81, PW'(8), 0, 0, 0, 1, 0);
    wave_idle(26, PW'(8), 0, 0);
    run_model();
    run_wave(1'b0);
    check("post_rst_byte", {24'd0, o_byte}, 32'h0000_0081);
    check("post_rst_dones", o_done, 1);
    check("post_rst_dv", {31'd0, o_dv}, 32'd1);

    // Randomized segments: random config, data, errors, gaps and sample flips.
    for (int s = 0; s < 10; s++) begin
      logic [PW-1:0] p;
      bit pe, pt;
      int nf, nflip, idx;
      wave_clear();
      p  = rand_p();
      pe = rbit();
      pt = rbit();
      wave_idle(3 + int'($urandom_range(5)), p, pe, pt);
      nf = 1 + int'($urandom_range(2));
      for (int f = 0; f < nf; f++) begin
        wave_frame(8'($urandom), p, pe, pt, ($urandom_range(3) == 0), ($urandom_range(4) != 0), rbit());
        wave_idle(int'($urandom_range(2 * int'(p))), p, pe, pt);
      end
      wave_idle(2 * int'(p) + 12, p, pe, pt);
      nflip = int'($urandom_range(3));
      for (int f = 0; f < nflip; f++) begin
        idx = int'($urandom_range(n_w - 1));
        rx_w[idx] = ~rx_w[idx];
      end
      run_model();
      run_wave(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
